// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a single 32-bit ALU.
// Each operation takes three cycles: accept (IDLE), execute (EXEC) and
// response handshake (RESP). Operands are registered before the ALU, and the
// result and flags are registered after it.
//
// Handshake rule for every port: a transfer happens on a rising clock edge
// where valid && ready are both high. A source holds valid and its payload
// stable until that edge. A request port may drop valid before it is granted.
// The response port holds rsp_valid and all rsp_* fields until rsp_ready.

module alu_rr_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              cout
);
    logic [DATA_W-1:0] b_eff;
    logic              cin;
    logic [DATA_W:0]   sum;

    // A single adder serves add (A+B+0) and sub (A+~B+1). For and/or the
    // carry is that of plain A+B.
    always_comb begin
        b_eff = (op == 2'b01) ? ~b : b;
        cin   = (op == 2'b01);
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
        case (op)
            2'b10:   result = a & b;
            2'b11:   result = a | b;
            default: result = sum[DATA_W-1:0];
        endcase
        cout = sum[DATA_W];
        zero = (result == '0);
    end
endmodule

module alu_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_cout,
    output logic              rsp_src,
    output logic [TAG_W-1:0]  rsp_tag
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [1:0]        opc_q, opc_d;
    logic [TAG_W-1:0]  optag_q, optag_d;
    logic              opsrc_q, opsrc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_src_q, rsp_src_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic              gnt0, gnt1;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_cout;

    alu_rr_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (opa_q),
        .b      (opb_q),
        .op     (opc_q),
        .result (alu_result),
        .zero   (alu_zero),
        .cout   (alu_cout)
    );

    // Grant only in IDLE. On contention, the requester that was not granted
    // last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Next-state logic. Every register holds its value unless its state acts.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        optag_d      = optag_q;
        opsrc_d      = opsrc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_src_d    = rsp_src_q;
        rsp_tag_d    = rsp_tag_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    opa_d        = gnt1 ? req1_a   : req0_a;
                    opb_d        = gnt1 ? req1_b   : req0_b;
                    opc_d        = gnt1 ? req1_op  : req0_op;
                    optag_d      = gnt1 ? req1_tag : req0_tag;
                    opsrc_d      = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_cout_d   = alu_cout;
                rsp_src_d    = opsrc_q;
                rsp_tag_d    = optag_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset discards any in-flight work and points
    // last_grant at requester 1, so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            optag_q      <= '0;
            opsrc_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_src_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            optag_q      <= optag_d;
            opsrc_q      <= opsrc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_src_q    <= rsp_src_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_src    = rsp_src_q;
    assign rsp_tag    = rsp_tag_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a transaction-level model with an expected queue,
// checked every cycle, plus directed scenarios with literal expectations.

module tb_alu_rr_arbiter;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [3:0]  tag;
    } op_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        src;
        logic [3:0]  tag;
        logic [1:0]  op;
    } rsp_t;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        src;
        logic [3:0]  tag;
        int          vis_cyc;
        int          hs_cyc;
    } obs_t;

    typedef struct {
        int   cyc;
        logic src;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_src;
    logic [3:0]  rsp_tag;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    op_t  q0[$], q1[$];
    rsp_t exp_q[$];
    bit   m_vis = 1'b0;
    logic m_last = 1'b1;
    obs_t rsp_log[$];
    acc_t acc_log[$];
    logic acc0_f = 1'b0, acc1_f = 1'b0;
    bit   vis_prev = 1'b0;
    int   vis_start = 0;

    alu_rr_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_cout   (rsp_cout),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op, input logic [3:0] tag);
        op_t o;
        o.a = a; o.b = b; o.op = op; o.tag = tag;
        return o;
    endfunction

    // Expected response straight from the arithmetic definitions.
    function automatic rsp_t model_op(input op_t o, input logic src);
        rsp_t r;
        r = '0;
        r.src = src;
        r.tag = o.tag;
        r.op  = o.op;
        case (o.op)
            2'd0: {r.cout, r.result} = {1'b0, o.a} + {1'b0, o.b};
            2'd1: begin
                r.result = o.a - o.b;
                r.cout   = (o.a >= o.b);
            end
            2'd2: r.result = o.a & o.b;
            default: r.result = o.a | o.b;
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rsp_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (rsp_log.size() < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout responses=%0d required=%0d", name, rsp_log.size(), n);
        end
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (acc_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (acc_log.size() < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout accepts=%0d required=%0d", name, acc_log.size(), n);
        end
    endtask

    // ---------------- requester drivers ----------------
    // Each requester presents the head of its queue and pops it after it is
    // accepted.
    always begin
        @(posedge clk);
        #2;
        if (acc0_f && q0.size() > 0) void'(q0.pop_front());
        if (acc1_f && q1.size() > 0) void'(q1.pop_front());
        req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin
            req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op; req0_tag = q0[0].tag;
        end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op; req1_tag = q1[0].tag;
        end
    end

    // ---------------- transaction model ----------------
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_vis  = 1'b0;
            m_last = 1'b1;
        end else if (exp_q.size() == 0) begin
            if (req0_valid && (!req1_valid || m_last == 1'b1)) begin
                exp_q.push_back(model_op(mk_op(req0_a, req0_b, req0_op, req0_tag), 1'b0));
                m_last = 1'b0;
            end else if (req1_valid) begin
                exp_q.push_back(model_op(mk_op(req1_a, req1_b, req1_op, req1_tag), 1'b1));
                m_last = 1'b1;
            end
        end else if (!m_vis) begin
            m_vis = 1'b1;
        end else if (rsp_ready) begin
            void'(exp_q.pop_front());
            m_vis = 1'b0;
        end
    end

    // ---------------- monitor and per-cycle compare ----------------
    always @(negedge clk) begin
        logic idle, e_g0, e_g1;
        acc0_f = rst_n && req0_valid && req0_ready;
        acc1_f = rst_n && req1_valid && req1_ready;
        if (acc0_f || acc1_f) acc_log.push_back('{cyc, acc1_f});
        if (rsp_valid && !vis_prev) vis_start = cyc;
        vis_prev = rsp_valid;
        if (rst_n && rsp_valid && rsp_ready)
            rsp_log.push_back('{rsp_result, rsp_zero, rsp_cout, rsp_src, rsp_tag, vis_start, cyc});
        if (chk_en) begin
            idle = (exp_q.size() == 0);
            e_g0 = idle && req0_valid && (!req1_valid || m_last == 1'b1);
            e_g1 = idle && req1_valid && (!req0_valid || m_last == 1'b0);
            chk("m_req0_ready", req0_ready, e_g0);
            chk("m_req1_ready", req1_ready, e_g1);
            chk("m_rsp_valid", rsp_valid, m_vis);
            if (m_vis && exp_q.size() > 0) begin
                chk("m_result", rsp_result, exp_q[0].result);
                chk("m_zero", rsp_zero, exp_q[0].zero);
                chk("m_src", rsp_src, exp_q[0].src);
                chk("m_tag", rsp_tag, exp_q[0].tag);
                if (exp_q[0].op == 2'd0 || exp_q[0].op == 2'd1)
                    chk("m_cout", rsp_cout, exp_q[0].cout);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state.
        rst_n = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_src", rsp_src, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        rst_n = 1'b1;
        step();

        // Single add, with latency.
        acc_log.delete(); rsp_log.delete();
        q0.push_back(mk_op(32'd5, 32'd3, 2'd0, 4'h2));
        wait_rsp(1, 20, "add");
        if (rsp_log.size() >= 1 && acc_log.size() >= 1) begin
            chk("add_result", rsp_log[0].result, 32'd8);
            chk("add_zero", rsp_log[0].zero, 0);
            chk("add_cout", rsp_log[0].cout, 0);
            chk("add_src", rsp_log[0].src, 0);
            chk("add_tag", rsp_log[0].tag, 4'h2);
            chk("add_latency", 32'(rsp_log[0].vis_cyc - acc_log[0].cyc), 32'd2);
        end

        // Sub with equal operands from requester 1.
        rsp_log.delete();
        q1.push_back(mk_op(32'h1234, 32'h1234, 2'd1, 4'h5));
        wait_rsp(1, 20, "sub_eq");
        if (rsp_log.size() >= 1) begin
            chk("sub_eq_result", rsp_log[0].result, 32'd0);
            chk("sub_eq_zero", rsp_log[0].zero, 1);
            chk("sub_eq_cout", rsp_log[0].cout, 1);
            chk("sub_eq_src", rsp_log[0].src, 1);
            chk("sub_eq_tag", rsp_log[0].tag, 4'h5);
        end

        // Borrow on sub, then carry-out on add.
        rsp_log.delete();
        q0.push_back(mk_op(32'd0, 32'd1, 2'd1, 4'h3));
        q0.push_back(mk_op(32'hFFFF_FFFF, 32'd1, 2'd0, 4'h4));
        wait_rsp(2, 30, "borrow");
        if (rsp_log.size() >= 2) begin
            chk("borrow_result", rsp_log[0].result, 32'hFFFF_FFFF);
            chk("borrow_zero", rsp_log[0].zero, 0);
            chk("borrow_cout", rsp_log[0].cout, 0);
            chk("wrap_result", rsp_log[1].result, 32'd0);
            chk("wrap_zero", rsp_log[1].zero, 1);
            chk("wrap_cout", rsp_log[1].cout, 1);
            chk("wrap_tag", rsp_log[1].tag, 4'h4);
        end

        // Contention from a fresh reset: grants alternate starting with 0.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        acc_log.delete(); rsp_log.delete();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk_op(32'(k * 7 + 1), 32'(k + 2), 2'(k), 4'(8 + k)));
            q1.push_back(mk_op(32'(k * 3 + 9), 32'(2 * k), 2'(3 - k), 4'(1 + k)));
        end
        wait_rsp(8, 50, "contention");
        if (rsp_log.size() >= 8 && acc_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("cont_src", rsp_log[i].src, 32'(i % 2));
                chk("cont_tag", rsp_log[i].tag, (i % 2 == 0) ? 32'(8 + i / 2) : 32'(1 + i / 2));
                chk("cont_acc_src", acc_log[i].src, 32'(i % 2));
                if (i > 0) chk("cont_acc_gap", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'd3);
            end
        end

        // Backpressure: response held for 5 cycles, no accepts meanwhile.
        acc_log.delete(); rsp_log.delete();
        rsp_ready = 1'b0;
        q0.push_back(mk_op(32'd100, 32'd50, 2'd1, 4'hC));
        q1.push_back(mk_op(32'd7, 32'd9, 2'd3, 4'hD));
        begin
            int k;
            k = 0;
            while (rsp_valid !== 1'b1 && k < 10) begin
                step();
                k++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 32'd50);
            chk("bp_src", rsp_src, 0);
            chk("bp_tag", rsp_tag, 4'hC);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        wait_rsp(1, 5, "bp_release");
        wait_acc(2, 5, "bp_next_grant");
        if (rsp_log.size() >= 1 && acc_log.size() >= 2) begin
            chk("bp_single_hs", rsp_log.size(), 1);
            chk("bp_next_cyc", 32'(acc_log[1].cyc - rsp_log[0].hs_cyc), 32'd1);
            chk("bp_next_src", acc_log[1].src, 1);
        end
        wait_rsp(2, 10, "bp_second");
        if (rsp_log.size() >= 2) chk("bp_or_result", rsp_log[1].result, 32'd15);

        // Reset during EXEC.
        acc_log.delete(); rsp_log.delete();
        q1.push_back(mk_op(32'h11, 32'h22, 2'd0, 4'h7));
        q0.push_back(mk_op(32'h11, 32'h22, 2'd0, 4'h6));
        wait_acc(1, 10, "rst_mid_accept");
        rst_n = 1'b0;
        step();
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_result", rsp_result, 0);
        chk("midrst_zero", rsp_zero, 0);
        chk("midrst_cout", rsp_cout, 0);
        chk("midrst_src", rsp_src, 0);
        chk("midrst_tag", rsp_tag, 0);
        q0.delete(); q1.delete();
        acc_log.delete(); rsp_log.delete();
        q0.push_back(mk_op(32'h11, 32'h22, 2'd0, 4'h6));
        q1.push_back(mk_op(32'h40, 32'h41, 2'd2, 4'h7));
        step();
        rst_n = 1'b1;
        wait_rsp(2, 20, "after_reset");
        if (rsp_log.size() >= 2 && acc_log.size() >= 2) begin
            chk("ar_first_src", acc_log[0].src, 0);
            chk("ar_result0", rsp_log[0].result, 32'h33);
            chk("ar_tag0", rsp_log[0].tag, 4'h6);
            chk("ar_src1", rsp_log[1].src, 1);
            chk("ar_result1", rsp_log[1].result, 32'h40);
        end

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
